// File: rtl/cdc_fifo_pkg.sv
// cdc_fifo_pkg: shared arbiter state type and packing offsets for the cdc_fifo source arbiter
package cdc_fifo_pkg;
  typedef enum logic [0:0] {ARB_IDLE = 1'b0, ARB_LOCKED = 1'b1} arb_state_t;
  function automatic int last_bit(input int dw);
    return dw;
  endfunction
  function automatic int id_lsb(input int dw);
    return dw + 1;
  endfunction
endpackage

// File: rtl/cdc_fifo_src_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first set req bit at or after ptr_i (wrapping)
//   req_i  : request vector
//   ptr_i  : round-robin start index
//   idx_o  : picked index (valid when any_o)
//   any_o  : at least one request set
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);
  logic [2*N-1:0] w_masked;
  int             w_pos;
  // The low copy loses bits below ptr; the untouched high copy supplies the wrap-around.
  always_comb begin
    w_masked = {req_i, req_i} & ~(((2*N)'(1) << ptr_i) - (2*N)'(1));
    w_pos = 0;
    for (int i = 2*N-1; i >= 0; i--) if (w_masked[i]) w_pos = i;
    idx_o = IW'(w_pos >= N ? w_pos - N : w_pos);
  end
  assign any_o = |req_i;
endmodule

// File: rtl/cdc_fifo_src_arb.sv
// cdc_fifo_src_arb: round-robin burst-locking arbiter sharing the cdc_fifo source side
//   clk_i, rst_n_i  : source clock, async active-low reset
//   req_valid_i/req_last_i/req_data_i : per-requester beat stream
//   req_ready_o     : per-requester ready, one-hot or zero
//   fifo_data_o     : {id, last, data} to cdc_fifo src_data_i
//   fifo_valid_o/fifo_ready_i : cdc_fifo source handshake
//   busy_o, grant_id_o : grant held / current or most recent grant index
module cdc_fifo_src_arb
  import cdc_fifo_pkg::*;
#(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int MAX_BURST  = 16,
  localparam int ID_WIDTH   = $clog2(NUM_REQ),
  localparam int CNT_WIDTH  = $clog2(MAX_BURST) + 1,
  localparam int OUT_WIDTH  = DATA_WIDTH + ID_WIDTH + 1
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NUM_REQ-1:0]                  req_valid_i,
  input  logic [NUM_REQ-1:0]                  req_last_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data_i,
  output logic [NUM_REQ-1:0]                  req_ready_o,
  output logic [OUT_WIDTH-1:0]                fifo_data_o,
  output logic                                fifo_valid_o,
  input  logic                                fifo_ready_i,
  output logic                                busy_o,
  output logic [ID_WIDTH-1:0]                 grant_id_o
);
  localparam int LAST_BIT = last_bit(DATA_WIDTH);
  localparam int ID_LSB   = id_lsb(DATA_WIDTH);
  arb_state_t           r_state;
  logic [ID_WIDTH-1:0]  r_rr_ptr, r_grant, w_pick, w_next_ptr;
  logic [CNT_WIDTH-1:0] r_beat_cnt;
  logic                 w_any, w_locked, w_last_eff, w_hs;
  rr_pick #(.N(NUM_REQ), .IW(ID_WIDTH)) u_pick (
    .req_i (req_valid_i),
    .ptr_i (r_rr_ptr),
    .idx_o (w_pick),
    .any_o (w_any)
  );
  assign w_locked     = r_state == ARB_LOCKED;
  assign w_last_eff   = req_last_i[r_grant] | (r_beat_cnt == CNT_WIDTH'(MAX_BURST - 1));
  assign fifo_valid_o = w_locked & req_valid_i[r_grant];
  assign w_hs         = fifo_valid_o & fifo_ready_i;
  assign req_ready_o  = w_locked ? NUM_REQ'(fifo_ready_i) << r_grant : '0;
  assign busy_o       = w_locked;
  assign grant_id_o   = r_grant;
  // Explicit modulo so a non-power-of-two NUM_REQ wraps to 0 rather than an unused index.
  assign w_next_ptr   = (r_grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : r_grant + 1'b1;
  always_comb begin
    fifo_data_o = '0;
    if (w_locked) begin
      fifo_data_o[DATA_WIDTH-1:0]     = req_data_i[r_grant];
      fifo_data_o[LAST_BIT]           = w_last_eff;
      fifo_data_o[OUT_WIDTH-1:ID_LSB] = r_grant;
    end
  end
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state    <= ARB_IDLE;
      r_rr_ptr   <= '0;
      r_grant    <= '0;
      r_beat_cnt <= '0;
    end else if (!w_locked) begin
      if (w_any) begin
        r_grant <= w_pick;
        r_state <= ARB_LOCKED;
      end
    end else if (w_hs) begin
      r_beat_cnt <= w_last_eff ? '0 : r_beat_cnt + 1'b1;
      if (w_last_eff) begin
        r_state  <= ARB_IDLE;
        r_rr_ptr <= w_next_ptr;
      end
    end
  end
  a_ready_onehot0: assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(req_ready_o));
  a_valid_held: assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (fifo_valid_o && !fifo_ready_i) |=> fifo_valid_o);
endmodule

// File: tb/tb_cdc_fifo_src_arb.sv
// tb_cdc_fifo_src_arb: directed self-checking bench for cdc_fifo_src_arb (4- and 3-requester instances)
module tb_cdc_fifo_src_arb;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic [3:0]       v4 = '0, l4 = '0, rdy4;
  logic [3:0][7:0]  d4 = '0;
  logic [10:0]      fd4;
  logic             fv4, fr4 = 1'b1, busy4;
  logic [1:0]       gid4;
  logic [2:0]       v3 = '0, l3 = '0, rdy3;
  logic [2:0][7:0]  d3 = '0;
  logic [10:0]      fd3;
  logic             fv3, fr3 = 1'b1, busy3;
  logic [1:0]       gid3;
  logic [10:0]      exp;
  int n_cmp = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  cdc_fifo_src_arb #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v4), .req_last_i(l4), .req_data_i(d4),
    .req_ready_o(rdy4), .fifo_data_o(fd4), .fifo_valid_o(fv4), .fifo_ready_i(fr4),
    .busy_o(busy4), .grant_id_o(gid4));
  cdc_fifo_src_arb #(.NUM_REQ(3), .DATA_WIDTH(8), .MAX_BURST(4)) dut3 (
    .clk_i(clk), .rst_n_i(rst_n), .req_valid_i(v3), .req_last_i(l3), .req_data_i(d3),
    .req_ready_o(rdy3), .fifo_data_o(fd3), .fifo_valid_o(fv3), .fifo_ready_i(fr3),
    .busy_o(busy3), .grant_id_o(gid3));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    #1 rst_n = 1'b0;
    v4 = 4'b0010;
    tick();
    tick();
    #2;
    n_cmp++; if (fv4 !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", fv4); end
    n_cmp++; if (rdy4 !== 4'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0000", rdy4); end
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy4); end
    n_cmp++; if (gid4 !== 2'd0) begin n_err++; $display("FAIL reset_gid: got %0d want 0", gid4); end
    n_cmp++; if (fd4 !== 11'h0) begin n_err++; $display("FAIL reset_data: got %h want 000", fd4); end
    n_cmp++; if (busy3 !== 1'b0 || fv3 !== 1'b0) begin n_err++; $display("FAIL reset_dut3: got busy=%b valid=%b want 0 0", busy3, fv3); end
    rst_n = 1'b1;
    v4 = '0;
  endtask
  task automatic test_single();
    tick();
    v4 = 4'b0010; d4[1] = 8'h0A;
    #2;
    n_cmp++; if (fv4 !== 1'b0 || busy4 !== 1'b0) begin n_err++; $display("FAIL single_latency: got valid=%b busy=%b want 0 0", fv4, busy4); end
    tick();
    #2;
    n_cmp++; if (gid4 !== 2'd1 || busy4 !== 1'b1) begin n_err++; $display("FAIL single_grant: got gid=%0d busy=%b want 1 1", gid4, busy4); end
    n_cmp++; if (rdy4 !== 4'b0010) begin n_err++; $display("FAIL single_ready: got %b want 0010", rdy4); end
    n_cmp++; if (fv4 !== 1'b1 || fd4 !== 11'h20A) begin n_err++; $display("FAIL single_beat1: got v=%b %h want 1 20a", fv4, fd4); end
    tick();
    d4[1] = 8'h0B;
    #2;
    n_cmp++; if (fd4 !== 11'h20B) begin n_err++; $display("FAIL single_beat2: got %h want 20b", fd4); end
    tick();
    d4[1] = 8'h0C; l4 = 4'b0010;
    #2;
    n_cmp++; if (fd4 !== 11'h30C) begin n_err++; $display("FAIL single_beat3: got %h want 30c", fd4); end
    tick();
    v4 = 4'b1011; l4 = 4'b1111; d4[3] = 8'h3F;
    #2;
    n_cmp++; if (busy4 !== 1'b0 || gid4 !== 2'd1) begin n_err++; $display("FAIL single_release: got busy=%b gid=%0d want 0 1", busy4, gid4); end
    tick();
    #2;
    n_cmp++; if (gid4 !== 2'd3 || fd4 !== 11'h73F) begin n_err++; $display("FAIL single_rrptr: got gid=%0d %h want 3 73f", gid4, fd4); end
    tick();
    v4 = '0; l4 = '0;
  endtask
  task automatic test_contention();
    int order [5] = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 4; i++) d4[i] = 8'h10 + 8'(i);
    v4 = 4'b1111; l4 = '0;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_cmp++; if (busy4 !== 1'b0 || fv4 !== 1'b0) begin n_err++; $display("FAIL cont_bubble%0d: got busy=%b valid=%b want 0 0", k, busy4, fv4); end
      tick();
      #2;
      exp = {2'(order[k]), 1'b0, 8'h10 + 8'(order[k])};
      n_cmp++; if (gid4 !== 2'(order[k]) || fd4 !== exp) begin n_err++; $display("FAIL cont_first%0d: got gid=%0d %h want %0d %h", k, gid4, fd4, order[k], exp); end
      n_cmp++; if (rdy4 !== 4'(1 << order[k])) begin n_err++; $display("FAIL cont_ready%0d: got %b want %b", k, rdy4, 4'(1 << order[k])); end
      tick();
      l4 = 4'b1111;
      #2;
      exp[8] = 1'b1;
      n_cmp++; if (gid4 !== 2'(order[k]) || fd4 !== exp) begin n_err++; $display("FAIL cont_second%0d: got gid=%0d %h want %0d %h", k, gid4, fd4, order[k], exp); end
      tick();
      l4 = '0;
    end
    v4 = '0;
  endtask
  task automatic test_forced_split();
    v4 = 4'b0100; l4 = '0;
    tick();
    for (int b = 1; b <= 6; b++) begin
      if (b == 5) begin
        #2;
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL split_bubble: got busy=%b want 0", busy4); end
        tick();
      end
      d4[2] = 8'h20 + 8'(b);
      l4[2] = (b == 6);
      #2;
      exp = {2'd2, b == 4 || b == 6, 8'h20 + 8'(b)};
      n_cmp++; if (gid4 !== 2'd2 || fv4 !== 1'b1 || fd4 !== exp) begin n_err++; $display("FAIL split_beat%0d: got gid=%0d v=%b %h want 2 1 %h", b, gid4, fv4, fd4, exp); end
      tick();
    end
    v4 = '0; l4 = '0;
    #2;
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL split_end: got busy=%b want 0", busy4); end
  endtask
  task automatic test_backpressure();
    tick();
    v4 = 4'b1000; l4 = '0; fr4 = 1'b1;
    tick();
    d4[3] = 8'h31;
    #2;
    n_cmp++; if (fd4 !== 11'h631 || rdy4 !== 4'b1000) begin n_err++; $display("FAIL bp_beat1: got %h rdy=%b want 631 1000", fd4, rdy4); end
    tick();
    d4[3] = 8'h32; fr4 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      n_cmp++; if (rdy4 !== 4'b0 || fv4 !== 1'b1 || fd4 !== 11'h632 || busy4 !== 1'b1) begin n_err++; $display("FAIL bp_stall%0d: got rdy=%b v=%b %h busy=%b want 0000 1 632 1", k, rdy4, fv4, fd4, busy4); end
      tick();
    end
    fr4 = 1'b1;
    #2;
    n_cmp++; if (fd4 !== 11'h632 || rdy4 !== 4'b1000) begin n_err++; $display("FAIL bp_resume: got %h rdy=%b want 632 1000", fd4, rdy4); end
    tick();
    d4[3] = 8'h33;
    #2;
    n_cmp++; if (fd4 !== 11'h633) begin n_err++; $display("FAIL bp_beat3: got %h want 633", fd4); end
    tick();
    d4[3] = 8'h34; l4 = 4'b1000;
    #2;
    n_cmp++; if (fd4 !== 11'h734) begin n_err++; $display("FAIL bp_beat4: got %h want 734", fd4); end
    tick();
    v4 = '0; l4 = '0;
    #2;
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL bp_end: got busy=%b want 0", busy4); end
  endtask
  task automatic test_reset_mid_burst();
    tick();
    v4 = 4'b0100; l4 = 4'b0100; d4[2] = 8'h51;
    tick();
    #2;
    n_cmp++; if (fd4 !== 11'h551) begin n_err++; $display("FAIL rst_pre: got %h want 551", fd4); end
    tick();
    l4 = '0;
    tick();
    d4[2] = 8'h52;
    tick();
    d4[2] = 8'h53;
    #2;
    n_cmp++; if (fv4 !== 1'b1 || rdy4 !== 4'b0100) begin n_err++; $display("FAIL rst_beat2: got v=%b rdy=%b want 1 0100", fv4, rdy4); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (fv4 !== 1'b0 || rdy4 !== 4'b0) begin n_err++; $display("FAIL rst_async: got v=%b rdy=%b want 0 0000", fv4, rdy4); end
    n_cmp++; if (busy4 !== 1'b0 || gid4 !== 2'd0 || fd4 !== 11'h0) begin n_err++; $display("FAIL rst_state: got busy=%b gid=%0d %h want 0 0 000", busy4, gid4, fd4); end
    v4 = 4'b1010; d4[1] = 8'h61;
    tick();
    #2 rst_n = 1'b1;
    #1;
    n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rst_idle: got busy=%b want 0", busy4); end
    tick();
    l4 = 4'b1010;
    #2;
    n_cmp++; if (gid4 !== 2'd1 || fd4 !== 11'h361) begin n_err++; $display("FAIL rst_first_grant: got gid=%0d %h want 1 361", gid4, fd4); end
    tick();
    v4 = '0; l4 = '0;
  endtask
  task automatic test_wrap();
    int order [4] = '{2, 0, 2, 0};
    for (int i = 0; i < 3; i++) d3[i] = 8'h40 + 8'(i);
    v3 = 3'b010; l3 = 3'b010;
    tick();
    #2;
    n_cmp++; if (gid3 !== 2'd1 || fd3 !== 11'h341) begin n_err++; $display("FAIL wrap_pre: got gid=%0d %h want 1 341", gid3, fd3); end
    tick();
    v3 = 3'b101; l3 = 3'b101;
    for (int k = 0; k < 4; k++) begin
      #2;
      n_cmp++; if (busy3 !== 1'b0) begin n_err++; $display("FAIL wrap_bubble%0d: got busy=%b want 0", k, busy3); end
      tick();
      #2;
      exp = {2'(order[k]), 1'b1, 8'h40 + 8'(order[k])};
      n_cmp++; if (gid3 !== 2'(order[k]) || fd3 !== exp || rdy3 !== 3'(1 << order[k])) begin n_err++; $display("FAIL wrap_grant%0d: got gid=%0d %h rdy=%b want %0d %h %b", k, gid3, fd3, rdy3, order[k], exp, 3'(1 << order[k])); end
      tick();
    end
    v3 = '0; l3 = '0;
  endtask
  initial begin
    test_reset();
    test_single();
    test_contention();
    test_forced_split();
    test_backpressure();
    test_reset_mid_burst();
    test_wrap();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/cdc_fifo_src_arb.md
Name: cdc_fifo_src_arb

Overview:
- Round-robin, burst-locking arbiter that shares the source (write) side of one cdc_fifo between NUM_REQ requesters in the source clock domain.
- Each beat is tagged with the requester index and an end-of-burst flag, so the destination side can demultiplex.
- Sits directly in front of cdc_fifo.src_*. The cdc_fifo DATA_WIDTH parameter is set to OUT_WIDTH.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 32, payload width per requester.
- MAX_BURST, 16, maximum beats per grant before a forced split (>=1; must be a power of two or any value <= 2**CNT_WIDTH).
- ID_WIDTH, $clog2(NUM_REQ), requester tag width (derived).
- CNT_WIDTH, $clog2(MAX_BURST)+1, beat counter width (derived).
- OUT_WIDTH, DATA_WIDTH+ID_WIDTH+1, packed output width (derived).

Ports:
- clk_i  in  1  source-domain clock.
- rst_n_i  in  1  reset; asynchronous assert, active-low.
- req_valid_i  in  NUM_REQ  per-requester valid.
- req_last_i  in  NUM_REQ  per-requester end-of-burst marker.
- req_data_i  in  NUM_REQ x DATA_WIDTH  per-requester payload.
- req_ready_o  out  NUM_REQ  per-requester ready; one-hot or zero.
- fifo_data_o  out  OUT_WIDTH  packed {id, last, data}, with id in the MSBs; drives cdc_fifo src_data_i.
- fifo_valid_o  out  1  drives src_valid_i.
- fifo_ready_i  in  1  from src_ready_o.
- busy_o  out  1  high while a grant is held (LOCKED).
- grant_id_o  out  ID_WIDTH  current or most recent grant index.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low, rst_n_i.
- Reset values:
  - state=IDLE; rr_ptr=0; grant=0; beat_cnt=0.
  - fifo_valid_o=0; req_ready_o=0; busy_o=0; grant_id_o=0; fifo_data_o=0.
- Reset mid-burst: immediate return to IDLE. Partially sent bursts are not completed. The FIFO keeps the beats already written.
- State IDLE:
  - fifo_valid_o=0 and req_ready_o=0.
  - If any req_valid_i is set, pick the first set bit at or after rr_ptr, wrapping modulo NUM_REQ.
  - Register that index into grant and go to LOCKED.
  - Arbitration latency is one cycle.
- State LOCKED:
  - fifo_valid_o = req_valid_i[grant].
  - fifo_data_o = {grant, last_eff, req_data_i[grant]}.
  - req_ready_o = fifo_ready_i << grant. Combinational pass-through; no data register.
  - Other requesters see ready=0.
- Handshake: hs = fifo_valid_o & fifo_ready_i.
  - On hs, beat_cnt increments.
  - last_eff = req_last_i[grant] | (beat_cnt == MAX_BURST-1).
- Exit condition: hs & last_eff.
  - Go to IDLE; rr_ptr = (grant+1) mod NUM_REQ, correct for non-power-of-two NUM_REQ; beat_cnt=0.
  - One idle bubble always separates grants.
- Forced split: at the MAX_BURST-th beat, the emitted last bit is 1 even if req_last is 0. The requester keeps its remaining beats and re-arbitrates normally.
- Valid drop mid-burst: the requester may deassert valid inside a burst. The lock is held, fifo_valid_o=0, and there is no timeout.
- FIFO full: fifo_ready_i=0 stalls the transfer. Data and valid pass through unchanged, so requesters must keep them stable per the valid/ready rule.
- Fairness: a requester waits at most NUM_REQ-1 bursts of at most MAX_BURST beats each, plus the bubbles.
- Status outputs: busy_o = (state==LOCKED); grant_id_o = grant.
- Protocol assertions in the bench/RTL (non-synthesis):
  - req_ready_o is $onehot0.
  - Under backpressure, fifo_valid_o does not fall without hs.

Decomposition:
- Shared package cdc_fifo_pkg holds:
  - the state enum (ARB_IDLE, ARB_LOCKED);
  - the packing helper constants ID_LSB and LAST_BIT.
- Sub-module rr_pick: purely combinational.
  - Inputs: req vector, ptr.
  - Outputs: index, any.
  - Uses a double-width masked priority-encoder technique.
  - Reusable by other arbiters.
- The top instantiates rr_pick, the FSM, beat_cnt, rr_ptr and the output mux.

Test Plan:
- Single requester: req1 sends 3 beats 0xA,0xB,0xC with last on the 3rd, fifo_ready=1 → FIFO receives id=1 with data A,B,C and last=0,0,1; the first beat appears 1 cycle after valid rises; busy drops after beat 3; rr_ptr=2.
- Contention: all 4 requesters valid with 2-beat bursts, rr_ptr=0 → grant order 0,1,2,3,0; exactly 1 idle cycle between bursts; no beats are interleaved.
- Forced split: MAX_BURST=4, req2 sends 6 beats with last only on the 6th → beats 1-4 carry last on beat 4; then requester 3 wins if valid, else req2 regains the grant and sends beats 5-6 with last on beat 6.
- Backpressure: fifo_ready held low for 5 cycles mid-burst → no handshake; req_ready_o=0; fifo_data_o stable; the burst resumes intact once ready returns.
- Wrap and fairness: NUM_REQ=3, only req0 and req2 valid, rr_ptr=2 → order 2,0,2,0; req1 never granted; grant_id_o tracks the order.
- Reset mid-burst: assert rst_n_i low during beat 2 of a 4-beat burst → fifo_valid_o and req_ready_o drop asynchronously; after release state=IDLE and rr_ptr=0, and the first grant goes to the lowest valid index.
